// File: rtl/bcd_chain_ctr_pkg.sv
// Shared constants, types and parameter checks for the multi-digit BCD
// counter and its per-digit slice.
package bcd_chain_ctr_pkg;

  localparam int           BCD_W      = 4;
  localparam logic [3:0]   BCD_NINE   = 4'h9;
  localparam int           MAX_DIGITS = 8;
  localparam int           MAX_VEC_W  = BCD_W * MAX_DIGITS;

  // What the whole chain does on a given edge.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_STEP = 2'd2,
    OP_WRAP = 2'd3
  } op_e;

  typedef struct packed {
    logic up;
    logic wrap;
  } mode_t;

  function automatic logic [BCD_W-1:0] digit_max_nib(
    input logic [MAX_VEC_W-1:0] max_vec,
    input int                   idx
  );
    return max_vec[idx*BCD_W +: BCD_W];
  endfunction

  // True when the digit count is in range and every used nibble is 1..9.
  function automatic bit params_ok(
    input int                   num_digits,
    input logic [MAX_VEC_W-1:0] max_vec
  );
    logic [BCD_W-1:0] nib;
    if (num_digits < 1 || num_digits > MAX_DIGITS) return 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < num_digits) begin
        nib = digit_max_nib(max_vec, i);
        if (nib == '0 || nib > BCD_NINE) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/bcd_chain_ctr_bcd_digit.sv
// One BCD digit with a compile-time maximum: clamped load, step up/down with
// roll-over at 0/max, and at_max/at_zero status for the chain's ripple logic.
module bcd_digit
  import bcd_chain_ctr_pkg::*;
(
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             up,
  input  logic [BCD_W-1:0] max,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] digit,
  output logic             at_max,
  output logic             at_zero
);

  logic [BCD_W-1:0] digit_d, digit_q;

  assign at_max  = (digit_q == max);
  assign at_zero = (digit_q == '0);
  assign digit   = digit_q;

  // NOTE: every always_comb output gets a default on entry so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // max never exceeds 9, so this also catches non-BCD nibbles A-F.
      digit_d = (load_val > max) ? max : load_val;
    end else if (step) begin
      if (up) digit_d = at_max  ? '0  : digit_q + 4'd1;
      else    digit_d = at_zero ? max : digit_q - 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) digit_q <= '0;
    else          digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_chain_ctr.sv
// Multi-digit BCD up/down counter with per-digit maxima, clamped load,
// wrap/saturate end mode, terminal-count pulse and end-of-range flag.
module bcd_chain_ctr
  import bcd_chain_ctr_pkg::*;
#(
  parameter int                          NUM_DIGITS = 4,
  parameter logic [BCD_W*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h5959
) (
  input  logic                          sys_clk,
  input  logic                          reset_n,
  input  logic                          count_enb,
  input  logic                          cfg_up,
  input  logic                          cfg_wrap,
  input  logic                          load_cnt,
  input  logic [BCD_W*NUM_DIGITS-1:0]   load_value,
  output logic [BCD_W*NUM_DIGITS-1:0]   count_out,
  output logic                          tc_pulse,
  output logic                          at_limit
);

  localparam logic [MAX_VEC_W-1:0] MAX_VEC = MAX_VEC_W'(DIGIT_MAX);

  if (!params_ok(NUM_DIGITS, MAX_VEC)) begin : g_param_error
    $error("bcd_chain_ctr: NUM_DIGITS must be 1..8 and each DIGIT_MAX nibble 1..9");
  end

  mode_t                mode;
  op_e                  op;
  logic [NUM_DIGITS-1:0] at_max, at_zero, lower_match, digit_step;
  logic [NUM_DIGITS:0]   ripple;
  logic                  at_end, step_en;
  logic                  tc_d, tc_q;

  assign mode = '{up: cfg_up, wrap: cfg_wrap};

  // ripple[i] is high when every digit below i sits at its end value for the
  // current direction; ripple[NUM_DIGITS] therefore marks end of range.
  assign lower_match = mode.up ? at_max : at_zero;

  always_comb begin
    ripple[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ripple[i+1] = ripple[i] & lower_match[i];
    end
  end

  assign at_end   = ripple[NUM_DIGITS];
  assign at_limit = at_end;

  always_comb begin
    op = OP_HOLD;
    if (load_cnt) begin
      op = OP_LOAD;
    end else if (count_enb) begin
      if (!at_end)        op = OP_STEP;
      else if (mode.wrap) op = OP_WRAP;
      else                op = OP_HOLD;
    end
  end

  // A wrap is an ordinary step in which every digit's ripple enable is set.
  assign step_en    = (op == OP_STEP) || (op == OP_WRAP);
  assign digit_step = ripple[NUM_DIGITS-1:0] & {NUM_DIGITS{step_en}};
  assign tc_d       = (op == OP_WRAP);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [BCD_W-1:0] MAX_I = digit_max_nib(MAX_VEC, i);

    bcd_digit u_digit (
      .sys_clk  (sys_clk),
      .reset_n  (reset_n),
      .step     (digit_step[i]),
      .up       (mode.up),
      .max      (MAX_I),
      .load     (op == OP_LOAD),
      .load_val (load_value[i*BCD_W +: BCD_W]),
      .digit    (count_out[i*BCD_W +: BCD_W]),
      .at_max   (at_max[i]),
      .at_zero  (at_zero[i])
    );
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) tc_q <= 1'b0;
    else          tc_q <= tc_d;
  end

  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_bcd_chain_ctr.sv
// Directed-vector bench for bcd_chain_ctr configured as a 4-digit mm:ss field
// (DIGIT_MAX = 5959).
module tb_bcd_chain_ctr;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        count_enb = 1'b0;
  logic        cfg_up = 1'b1;
  logic        cfg_wrap = 1'b1;
  logic        load_cnt = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] count_out;
  logic        tc_pulse;
  logic        at_limit;

  int vectors = 0;
  int miscompares = 0;

  bcd_chain_ctr #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5959)) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .count_enb  (count_enb),
    .cfg_up     (cfg_up),
    .cfg_wrap   (cfg_wrap),
    .load_cnt   (load_cnt),
    .load_value (load_value),
    .count_out  (count_out),
    .tc_pulse   (tc_pulse),
    .at_limit   (at_limit)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] val);
    load_cnt   = 1'b1;
    load_value = val;
    tick();
    load_cnt   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cfg_up  = 1'b0;
    #3;
    vectors++;
    if (count_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_count: got %h want 0000", count_out);
    end
    vectors++;
    if (tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tc: got %b want 0", tc_pulse);
    end
    vectors++;
    if (at_limit !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_limit_down: got %b want 1", at_limit);
    end
    cfg_up = 1'b1;
    #1;
    vectors++;
    if (at_limit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_limit_up: got %b want 0", at_limit);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_count_up();
    int tc_seen = 0;
    cfg_up    = 1'b1;
    cfg_wrap  = 1'b1;
    count_enb = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tc_pulse === 1'b1) tc_seen++;
    end
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h0100) begin
      miscompares++;
      $display("FAIL count_60: got %h want 0100", count_out);
    end
    vectors++;
    if (tc_seen != 0) begin
      miscompares++;
      $display("FAIL count_60_tc: got %0d pulses want 0", tc_seen);
    end
    tick();
    vectors++;
    if (count_out !== 16'h0100) begin
      miscompares++;
      $display("FAIL idle_hold: got %h want 0100", count_out);
    end
    // Asynchronous reset between edges must clear the count at once.
    count_enb = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (count_out !== 16'h0000 || tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %h/%b want 0000/0", count_out, tc_pulse);
    end
    count_enb = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (count_out !== 16'h0000 || tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got %h/%b want 0000/0", count_out, tc_pulse);
    end
  endtask

  task automatic test_wrap_up();
    cfg_up   = 1'b1;
    cfg_wrap = 1'b1;
    do_load(16'h5959);
    vectors++;
    if (count_out !== 16'h5959 || at_limit !== 1'b1 || tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_up_pre: got %h/%b/%b want 5959/1/0", count_out, at_limit, tc_pulse);
    end
    count_enb = 1'b1;
    tick();
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h0000 || tc_pulse !== 1'b1 || at_limit !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_up: got %h/%b/%b want 0000/1/0", count_out, tc_pulse, at_limit);
    end
    tick();
    vectors++;
    if (tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_up_tc_once: got %b want 0", tc_pulse);
    end
  endtask

  task automatic test_wrap_down();
    cfg_up   = 1'b0;
    cfg_wrap = 1'b1;
    #1;
    vectors++;
    if (at_limit !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_limit_down: got %b want 1", at_limit);
    end
    count_enb = 1'b1;
    tick();
    vectors++;
    if (count_out !== 16'h5959 || tc_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_down: got %h/%b want 5959/1", count_out, tc_pulse);
    end
    tick();
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h5958 || tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_down_next: got %h/%b want 5958/0", count_out, tc_pulse);
    end
  endtask

  task automatic test_ripple();
    cfg_up = 1'b0;
    do_load(16'h1000);
    count_enb = 1'b1;
    tick();
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h0959) begin
      miscompares++;
      $display("FAIL ripple_down: got %h want 0959", count_out);
    end
    cfg_up    = 1'b1;
    count_enb = 1'b1;
    tick();
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h1000 || tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple_up: got %h/%b want 1000/0", count_out, tc_pulse);
    end
  endtask

  task automatic test_saturate();
    int tc_seen = 0;
    cfg_up   = 1'b1;
    cfg_wrap = 1'b0;
    do_load(16'h5959);
    count_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tc_pulse !== 1'b0) tc_seen++;
    end
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h5959 || at_limit !== 1'b1 || tc_seen != 0) begin
      miscompares++;
      $display("FAIL saturate_up: got %h/%b/%0d want 5959/1/0", count_out, at_limit, tc_seen);
    end
    cfg_up    = 1'b0;
    count_enb = 1'b1;
    tick();
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h5958 || tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate_flip: got %h/%b want 5958/0", count_out, tc_pulse);
    end
    // Saturate at zero going down.
    do_load(16'h0000);
    count_enb = 1'b1;
    tick();
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h0000 || tc_pulse !== 1'b0 || at_limit !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate_down: got %h/%b/%b want 0000/0/1", count_out, tc_pulse, at_limit);
    end
  endtask

  task automatic test_clamp();
    do_load(16'h7A99);
    vectors++;
    if (count_out !== 16'h5959) begin
      miscompares++;
      $display("FAIL clamp_7a99: got %h want 5959", count_out);
    end
    do_load(16'h0F3C);
    vectors++;
    if (count_out !== 16'h0939) begin
      miscompares++;
      $display("FAIL clamp_0f3c: got %h want 0939", count_out);
    end
  endtask

  task automatic test_load_priority();
    cfg_up   = 1'b1;
    cfg_wrap = 1'b1;
    do_load(16'h5959);
    // Load with enable at end of range: no step, no wrap pulse.
    count_enb  = 1'b1;
    load_cnt   = 1'b1;
    load_value = 16'h1234;
    tick();
    load_cnt = 1'b0;
    vectors++;
    if (count_out !== 16'h1234 || tc_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL load_over_count: got %h/%b want 1234/0", count_out, tc_pulse);
    end
    tick();
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h1235) begin
      miscompares++;
      $display("FAIL step_after_load: got %h want 1235", count_out);
    end
  endtask

  task automatic test_back_to_back();
    int tc_count = 0;
    cfg_up   = 1'b1;
    cfg_wrap = 1'b1;
    do_load(16'h5958);
    count_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tc_pulse === 1'b1) tc_count++;
    end
    count_enb = 1'b0;
    vectors++;
    if (count_out !== 16'h0001 || tc_count != 1) begin
      miscompares++;
      $display("FAIL back_to_back: got %h/%0d pulses want 0001/1", count_out, tc_count);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_ripple();
    test_saturate();
    test_clamp();
    test_load_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_chain_ctr.md
Name: bcd_chain_ctr

Overview:
Parametrised multi-digit BCD up/down counter. Each digit has its own compile-time maximum, so one instance can count as a plain decimal counter (all digits 9) or as a time field (for example mm:ss, using 5/9 digits). It adds synchronous load with per-digit clamping, a wrap or saturate end mode, a one-cycle terminal-count pulse and a limit flag. It is the building block for the stopwatch/timer datapath and replaces chains of single-digit counters.

Parameters:
NUM_DIGITS, 4, number of BCD digits; legal range 1..8.
DIGIT_MAX, 16'h5959, packed per-digit maximum (4 bits per digit, digit 0 in the LSBs); each nibble must be 1..9.

Ports:
sys_clk  input  1  clock.
reset_n  input  1  reset, asynchronous, active-low.
count_enb  input  1  advance the counter by one step on this edge.
cfg_up  input  1  1 = count up, 0 = count down.
cfg_wrap  input  1  1 = wrap at end of range, 0 = saturate at end of range.
load_cnt  input  1  synchronous load request.
load_value  input  4*NUM_DIGITS  load data, packed BCD.
count_out  output  4*NUM_DIGITS  current count, packed BCD, registered.
tc_pulse  output  1  registered pulse, high for one cycle after a wrap.
at_limit  output  1  count is at the end of range for the current direction.

Behaviour:
- Reset (reset_n low, asynchronous): count_out = 0 and tc_pulse = 0 immediately, held until release.
- Edge priority: reset, then load, then count. All decisions use cfg_up and cfg_wrap as sampled on the same edge. A mode change takes effect on the next edge.
- Load (load_cnt = 1):
  - Each digit i takes min(load_value[i], DIGIT_MAX[i]).
  - Non-BCD nibbles (A-F) and over-max nibbles are clamped to DIGIT_MAX[i].
  - tc_pulse = 0 on a load edge; count_enb is ignored.
- Count up (count_enb = 1, cfg_up = 1):
  - Digit 0 always steps.
  - Digit i steps only when every lower digit equals its DIGIT_MAX.
  - A stepping digit at DIGIT_MAX goes to 0; otherwise it increments.
- Count down (count_enb = 1, cfg_up = 0):
  - Digit i steps only when every lower digit equals 0.
  - A stepping digit at 0 goes to DIGIT_MAX[i]; otherwise it decrements.
- End of range: all digits at DIGIT_MAX (up) or all digits 0 (down).
  - cfg_wrap = 1: full wrap (all-max to all-zero, or all-zero to all-max); tc_pulse = 1 for exactly the cycle after that edge.
  - cfg_wrap = 0: count holds, tc_pulse stays 0.
- tc_pulse is 0 on every edge that is not a wrap. Back-to-back wraps are only possible when the range has one state, and then tc_pulse stays high.
- count_enb = 0: count holds, tc_pulse = 0.
- at_limit: combinational from the registered count_out and cfg_up. Equals 1 when count_out is at the end of range for the current direction, regardless of cfg_wrap.
- Latency: count_out and tc_pulse update on the edge where the step occurs. No internal pipelining.
- Ripple condition: computed combinationally across all digits in the same cycle; no multi-cycle carry.
- Reset asserted mid-count or mid-load: the operation is abandoned; no tc_pulse after release.
- Illegal DIGIT_MAX nibble (0 or greater than 9) or NUM_DIGITS out of range: elaboration-time error.

Decomposition:
- Shared package: BCD_W = 4; BCD_NINE = 4'h9; a function returning the DIGIT_MAX nibble for a digit index; a parameter-check macro/function.
- One natural sub-module, bcd_digit, generated NUM_DIGITS times:
  - inputs: step, up, max, load, load_val
  - outputs: digit, at_max, at_zero
- The top level builds the ripple enables (AND of lower at_max/at_zero), the end-of-range detect, tc_pulse and at_limit.

Test Plan:
1. Reset, then cfg_up = 1, count_enb = 1 for 60 cycles -> count_out = 16'h0100; tc_pulse never high; assert reset_n low mid-count -> count_out = 0 immediately.
2. Load 16'h5959, cfg_wrap = 1, cfg_up = 1, one enable -> count_out = 16'h0000, tc_pulse high for exactly one cycle, at_limit drops.
3. From 16'h0000, cfg_up = 0, cfg_wrap = 1, one enable -> count_out = 16'h5959, tc_pulse high one cycle; a further enable -> 16'h5958.
4. Load 16'h5959, cfg_wrap = 0, cfg_up = 1, 5 enables -> count_out stays 16'h5959, at_limit = 1, tc_pulse = 0; flip cfg_up = 0, one enable -> 16'h5958.
5. Load 16'h7A99 -> count_out = 16'h5959 (clamped); load 16'h0F3C -> 16'h0939.
6. load_cnt and count_enb both high with load_value 16'h1234 -> count_out = 16'h1234, no step, tc_pulse = 0; next enable (up) -> 16'h1235.
